// File: rtl/evu_pkg.sv
// Shared definitions for the event counter bank: CONFIG register layout,
// event-select codes (same encoding as the upstream event muxes) and the
// register offset selected by address bit 0.
package evu_pkg;

  // CONFIG register: [3:0] SEL, [4] EN, [5] IRQ_EN, [6] OVF (sticky, W1C)
  typedef struct packed {
    logic       ovf;
    logic       irq_en;
    logic       en;
    logic [3:0] sel;
  } evu_cfg_t;

  localparam int unsigned EVU_OVF_BIT = 6;

  // Event codes, matching the mux encoding
  localparam logic [3:0] EVU_ICACHE_MISS   = 4'h2;
  localparam logic [3:0] EVU_DCACHE_MISS   = 4'h3;
  localparam logic [3:0] EVU_ITLB_MISS     = 4'h4;
  localparam logic [3:0] EVU_DTLB_MISS     = 4'h5;
  localparam logic [3:0] EVU_LOAD          = 4'h6;
  localparam logic [3:0] EVU_STORE         = 4'h7;
  localparam logic [3:0] EVU_EXCEPTION     = 4'h8;
  localparam logic [3:0] EVU_EXC_RET       = 4'h9;
  localparam logic [3:0] EVU_BRANCH        = 4'hA;
  localparam logic [3:0] EVU_BRANCH_MISS   = 4'hB;
  localparam logic [3:0] EVU_CALL          = 4'hC;
  localparam logic [3:0] EVU_RET           = 4'hD;
  localparam logic [3:0] EVU_MIS_FLUSH     = 4'hE;
  localparam logic [3:0] EVU_IF_EMPTY      = 4'hF;

  // Register offsets (address bit 0)
  localparam logic EVU_REG_COUNT  = 1'b0;
  localparam logic EVU_REG_CONFIG = 1'b1;

endpackage

// File: rtl/evu_counter_slice.sv
// One event counter: count register, CONFIG register and the
// increment / wrap / sticky-overflow logic.
// Optional macro EVU_SNAPSHOT_EN exports the next-state count for snapshots.
module evu_counter_slice
  import evu_pkg::*;
#(
  parameter int unsigned CNT_W  = 64,
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              evt_i,
  input  logic              inhibit_i,
  input  logic              cnt_we_i,
  input  logic              cfg_we_i,
  input  logic [DATA_W-1:0] wdata_i,
`ifdef EVU_SNAPSHOT_EN
  output logic [CNT_W-1:0]  count_nxt_o,
`endif
  output logic [CNT_W-1:0]  count_o,
  output evu_cfg_t          cfg_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_nxt;
  evu_cfg_t         cfg_q;
  logic             inc;
  logic             wrap;

  assign inc  = evt_i & cfg_q.en & ~inhibit_i;
  // A COUNT write replaces the increment, so it can never cause a wrap
  assign wrap = inc & ~cnt_we_i & (&count_q);

  // Next count: a register write wins over a same-cycle increment
  always_comb begin
    count_nxt = count_q;
    if (cnt_we_i) begin
      count_nxt = wdata_i[CNT_W-1:0];
    end else if (inc) begin
      count_nxt = count_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_nxt;
    end
  end

  // CONFIG register; a wrap sets OVF even when the same write clears it
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cfg_q <= '0;
    end else begin
      if (cfg_we_i) begin
        cfg_q.sel    <= wdata_i[3:0];
        cfg_q.en     <= wdata_i[4];
        cfg_q.irq_en <= wdata_i[5];
      end
      cfg_q.ovf <= wrap | (cfg_q.ovf & ~(cfg_we_i & wdata_i[EVU_OVF_BIT]));
    end
  end

  assign count_o = count_q;
  assign cfg_o   = cfg_q;
`ifdef EVU_SNAPSHOT_EN
  assign count_nxt_o = count_nxt;
`endif

endmodule

// File: rtl/evu_counter_bank.sv
// Bank of NUM_CNT programmable event counters with a single-port register
// interface (1-cycle read latency) and a level overflow interrupt.
// Optional macro EVU_SNAPSHOT_EN adds snap_i, per-counter shadow registers
// and one extra address MSB selecting the read-only shadows.
module evu_counter_bank
  import evu_pkg::*;
#(
  parameter int unsigned NUM_CNT = 4,
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned DATA_W  = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_CNT-1:0]       evt_i,
  output logic [4*NUM_CNT-1:0]     sel_o,
  input  logic                     inhibit_i,
`ifdef EVU_SNAPSHOT_EN
  input  logic                     snap_i,
  input  logic [$clog2(NUM_CNT)+1:0] addr_i,
`else
  input  logic [$clog2(NUM_CNT):0] addr_i,
`endif
  input  logic                     req_i,
  input  logic                     we_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic                     rvalid_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     irq_o
);

  localparam int unsigned AW = $bits(addr_i);

  logic [CNT_W-1:0] count [NUM_CNT];
  evu_cfg_t         cfg   [NUM_CNT];
  logic [AW-1:0]    idx;
  logic             shadow_sel;
  logic             wr;
  logic             rd;
  logic [DATA_W-1:0] rd_val;
  logic             irq_d;

`ifdef EVU_SNAPSHOT_EN
  logic [CNT_W-1:0] count_nxt [NUM_CNT];
  logic [CNT_W-1:0] shadow    [NUM_CNT];

  assign shadow_sel = addr_i[AW-1];
  assign idx        = {1'b0, addr_i[AW-2:0]} >> 1;
`else
  assign shadow_sel = 1'b0;
  assign idx        = addr_i >> 1;
`endif

  // Shadows are read-only, so a write with the shadow bit set goes nowhere
  assign wr = req_i & we_i & ~shadow_sel;
  assign rd = req_i & ~we_i;

  for (genvar k = 0; k < NUM_CNT; k++) begin : g_slice
    logic hit;
    assign hit = wr & (idx == AW'(k));

    evu_counter_slice #(
      .CNT_W  (CNT_W),
      .DATA_W (DATA_W)
    ) u_slice (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .evt_i       (evt_i[k]),
      .inhibit_i   (inhibit_i),
      .cnt_we_i    (hit & (addr_i[0] == EVU_REG_COUNT)),
      .cfg_we_i    (hit & (addr_i[0] == EVU_REG_CONFIG)),
      .wdata_i     (wdata_i),
`ifdef EVU_SNAPSHOT_EN
      .count_nxt_o (count_nxt[k]),
`endif
      .count_o     (count[k]),
      .cfg_o       (cfg[k])
    );

    assign sel_o[4*k +: 4] = cfg[k].sel;
  end

  // Read mux on pre-edge state; an index beyond NUM_CNT reads as zero
  always_comb begin
    rd_val = '0;
    for (int unsigned k = 0; k < NUM_CNT; k++) begin
      if (idx == AW'(k)) begin
`ifdef EVU_SNAPSHOT_EN
        if (shadow_sel) begin
          rd_val = DATA_W'(shadow[k]);
        end else
`endif
        if (addr_i[0] == EVU_REG_CONFIG) begin
          rd_val = DATA_W'(cfg[k]);
        end else begin
          rd_val = DATA_W'(count[k]);
        end
      end
    end
  end

  // Interrupt source: any counter with both OVF and IRQ_EN set
  always_comb begin
    irq_d = 1'b0;
    for (int unsigned k = 0; k < NUM_CNT; k++) begin
      irq_d = irq_d | (cfg[k].ovf & cfg[k].irq_en);
    end
  end

  // Registered read response and interrupt; rdata holds between reads
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
      irq_o    <= 1'b0;
    end else begin
      rvalid_o <= rd;
      if (rd) begin
        rdata_o <= rd_val;
      end
      irq_o <= irq_d;
    end
  end

`ifdef EVU_SNAPSHOT_EN
  // Snapshot captures the post-increment value of every counter in one edge
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < NUM_CNT; k++) begin
        shadow[k] <= '0;
      end
    end else if (snap_i) begin
      for (int unsigned k = 0; k < NUM_CNT; k++) begin
        shadow[k] <= count_nxt[k];
      end
    end
  end
`endif

endmodule

// File: tb/tb_evu_counter_bank.sv
// Directed self-checking bench for evu_counter_bank. A second, narrower
// instance (3 counters, 16-bit counts) covers out-of-range indices and
// zero-extension of short counts.
`timescale 1ns/1ps
module tb_evu_counter_bank;

`ifdef EVU_SNAPSHOT_EN
  localparam int unsigned AW = 4;
`else
  localparam int unsigned AW = 3;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [3:0]    evt;
  logic [15:0]   sel;
  logic          inhibit;
  logic          req;
  logic          we;
  logic [AW-1:0] addr;
  logic [63:0]   wdata;
  logic          rvalid;
  logic [63:0]   rdata;
  logic          irq;

  logic [2:0]    evt3;
  logic [11:0]   sel3;
  logic          req3;
  logic          we3;
  logic [AW-1:0] addr3;
  logic [63:0]   wdata3;
  logic          rvalid3;
  logic [63:0]   rdata3;
  logic          irq3;

`ifdef EVU_SNAPSHOT_EN
  logic          snap;
  logic          snap3;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  evu_counter_bank #(
    .NUM_CNT (4),
    .CNT_W   (64),
    .DATA_W  (64)
  ) u_dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .evt_i     (evt),
    .sel_o     (sel),
    .inhibit_i (inhibit),
`ifdef EVU_SNAPSHOT_EN
    .snap_i    (snap),
`endif
    .req_i     (req),
    .we_i      (we),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rvalid_o  (rvalid),
    .rdata_o   (rdata),
    .irq_o     (irq)
  );

  evu_counter_bank #(
    .NUM_CNT (3),
    .CNT_W   (16),
    .DATA_W  (64)
  ) u_dut3 (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .evt_i     (evt3),
    .sel_o     (sel3),
    .inhibit_i (1'b0),
`ifdef EVU_SNAPSHOT_EN
    .snap_i    (snap3),
`endif
    .req_i     (req3),
    .we_i      (we3),
    .addr_i    (addr3),
    .wdata_i   (wdata3),
    .rvalid_o  (rvalid3),
    .rdata_o   (rdata3),
    .irq_o     (irq3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int unsigned a, input logic [63:0] d);
    req = 1'b1; we = 1'b1; addr = AW'(a); wdata = d;
    tick();
    req = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input string tag, input int unsigned a, input logic [63:0] expv);
    req = 1'b1; we = 1'b0; addr = AW'(a);
    tick();
    req = 1'b0;
    check({tag, ".rvalid"}, 64'(rvalid), 64'd1);
    check(tag, rdata, expv);
  endtask

  task automatic wr3(input int unsigned a, input logic [63:0] d);
    req3 = 1'b1; we3 = 1'b1; addr3 = AW'(a); wdata3 = d;
    tick();
    req3 = 1'b0; we3 = 1'b0;
  endtask

  task automatic rd3(input string tag, input int unsigned a, input logic [63:0] expv);
    req3 = 1'b1; we3 = 1'b0; addr3 = AW'(a);
    tick();
    req3 = 1'b0;
    check({tag, ".rvalid"}, 64'(rvalid3), 64'd1);
    check(tag, rdata3, expv);
  endtask

  // Hard stop in case the stimulus never completes
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] exp_b2b [4];

    rst_n = 1'b0; evt = '1; inhibit = 1'b0;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    evt3 = '0; req3 = 1'b0; we3 = 1'b0; addr3 = '0; wdata3 = '0;
`ifdef EVU_SNAPSHOT_EN
    snap = 1'b0; snap3 = 1'b0;
`endif

    // 1. Reset with all events high
    tick();
    tick();
    check("rst.sel", 64'(sel), 64'h0);
    check("rst.irq", 64'(irq), 64'h0);
    check("rst.rvalid", 64'(rvalid), 64'h0);
    check("rst.rdata", rdata, 64'h0);
    rst_n = 1'b1;
    tick();
    evt = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      rd($sformatf("rst.cnt%0d", k), k << 1, 64'h0);
      rd($sformatf("rst.cfg%0d", k), (k << 1) | 1, 64'h0);
    end
    check("rst.rvalid_pulse", 64'(rvalid), 64'h1);
    tick();
    check("rvalid_drop", 64'(rvalid), 64'h0);

    // 2. Basic counting with inhibit on cycles 4-5
    wr(3, 64'h13);
    check("cnt.sel1", 64'(sel), 64'h0030);
    evt = 4'b0010;
    for (int c = 1; c <= 10; c++) begin
      inhibit = (c == 4 || c == 5);
      tick();
    end
    evt = '0; inhibit = 1'b0;
    rd("cnt.cnt1", 2, 64'd8);

    // 3. Overflow and interrupt
    wr(1, 64'h31);
    wr(0, 64'hFFFF_FFFF_FFFF_FFFE);
    evt = 4'b0001;
    tick();
    tick();
    evt = '0;
    check("ovf.irq_wrap_edge", 64'(irq), 64'h0);
    tick();
    check("ovf.irq_next", 64'(irq), 64'h1);
    rd("ovf.cnt0", 0, 64'h0);
    rd("ovf.cfg0", 1, 64'h71);
    wr(1, 64'h71);
    check("ovf.irq_clr_edge", 64'(irq), 64'h1);
    tick();
    check("ovf.irq_cleared", 64'(irq), 64'h0);
    rd("ovf.cfg0_after", 1, 64'h31);

    // 4. Collisions: COUNT write vs increment, W1C vs wrap
    wr(5, 64'h10);
    evt = 4'b0100;
    wr(4, 64'd5);
    evt = '0;
    rd("col.cnt2", 4, 64'd5);
    wr(7, 64'h10);
    wr(6, '1);
    evt = 4'b1000;
    wr(7, 64'h50);
    evt = '0;
    rd("col.cfg3", 7, 64'h50);
    rd("col.cnt3", 6, 64'h0);
    check("col.irq", 64'(irq), 64'h0);

    // 5. Back-to-back reads of all counters
    wr(0, 64'hA5A5_0000_1111_2222);
    wr(6, 64'h1234);
    exp_b2b[0] = 64'hA5A5_0000_1111_2222;
    exp_b2b[1] = 64'd8;
    exp_b2b[2] = 64'd5;
    exp_b2b[3] = 64'h1234;
    req = 1'b1; we = 1'b0;
    for (int unsigned k = 0; k < 4; k++) begin
      addr = AW'(k << 1);
      tick();
      check($sformatf("b2b.rvalid%0d", k), 64'(rvalid), 64'h1);
      check($sformatf("b2b.rdata%0d", k), rdata, exp_b2b[k]);
    end
    req = 1'b0;
    tick();
    check("b2b.rvalid_end", 64'(rvalid), 64'h0);
    check("b2b.rdata_hold", rdata, 64'h1234);

    // Out-of-range index and short-count zero-extension (3-counter instance)
    wr3(4, 64'hFFFF_FFFF_FFFF_ABCD);
    wr3(6, 64'h55);
    rd3("oor.cnt2", 4, 64'hABCD);
    rd3("oor.cnt3", 6, 64'h0);
    rd3("oor.cfg3", 7, 64'h0);
    check("oor.irq", 64'(irq3), 64'h0);

`ifdef EVU_SNAPSHOT_EN
    // 6. Snapshot captures post-increment values
    wr(0, 64'd7);
    wr(2, 64'd9);
    evt = 4'b0011;
    snap = 1'b1;
    tick();
    snap = 1'b0;
    tick();
    tick();
    tick();
    evt = '0;
    rd("snap.shadow0", 8, 64'd8);
    rd("snap.shadow1", 10, 64'd10);
    wr(8, 64'hDEAD);
    wr(9, 64'h77);
    rd("snap.shadow0_wr", 8, 64'd8);
    rd("snap.live0", 0, 64'd11);
    rd("snap.live1", 2, 64'd13);
    rd("snap.cfg0", 1, 64'h31);
`endif

    // Reset during a pending read discards it
    req = 1'b1; we = 1'b0; addr = AW'(2);
    rst_n = 1'b0;
    tick();
    req = 1'b0;
    check("rst2.rvalid", 64'(rvalid), 64'h0);
    check("rst2.rdata", rdata, 64'h0);
    check("rst2.sel", 64'(sel), 64'h0);
    rst_n = 1'b1;
    rd("rst2.cnt1", 2, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
